jtag_scan_master: RTL and testbench
===================================

# jtag_scan_master

Host-side JTAG initiator that bit-bangs TCK/TMS/TDI to run complete IR or DR scans against a RISC-V debug transport module's TAP, such as the DTMCS/DMI capture-update chains. It accepts one scan request (length, data, IR/DR select) over a valid/ready port and generates the full TAP state walk from Run-Test/Idle back to Run-Test/Idle. It returns the TDO bits captured during Shift on a valid/ready response port. It serves as the test/bring-up driver that exercises the debug chain from the far end.

## Interface
Parameters:
- MAX_LEN, 41: maximum scan length in bits; 41 is the DMI width (7 addr + 32 data + 2 op).
- CLK_DIV, 2: system clocks per TCK half-period; must be ≥ 2.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  scan request valid.
- req_ready  out  1  block idle and able to accept a request.
- req_ir  in  1  1 = IR scan, 0 = DR scan.
- req_len  in  $clog2(MAX_LEN+1)  bit count; values > MAX_LEN are clamped to MAX_LEN.
- req_data  in  MAX_LEN  TDI bits, bit 0 shifted first.
- resp_valid  out  1  scan complete.
- resp_ready  in  1  response consumed.
- resp_data  out  MAX_LEN  TDO bits; bit i is sampled at shift edge i; bits ≥ len are 0.
- jtag_tck  out  1  test clock.
- jtag_tms  out  1  test mode select.
- jtag_tdi  out  1  test data to the target.
- jtag_tdo  in  1  test data from the target.

## Operation
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=1, req_ready=0, resp_valid=0, resp_data=0.
- States: INIT → IDLE → PRE → SHIFT → POST → RESP → IDLE.
- INIT:
  - Entered on every reset, including reset mid-scan.
  - Issues 6 TCK cycles with TMS = 1,1,1,1,1,0, forcing the target TAP through Test-Logic-Reset into Run-Test/Idle.
- IDLE:
  - req_ready=1, tms=0, tdi=1, tck=0.
  - Handshake (req_valid & req_ready) latches req_ir, clamped length L and req_data.
  - Clears resp_data.
  - Moves to PRE.
- PRE TMS sequence:
  - DR, L ≥ 1: 1,0,0 (Select, Capture, Shift-DR).
  - IR, L ≥ 1: 1,1,0,0.
  - L = 0: the final 0 is replaced with 1 (Capture → Exit1), so DR is 1,0,1 and IR is 1,1,0,1, and SHIFT is skipped.
  - tdi=1 throughout PRE.
- SHIFT:
  - L TCK cycles; cycle i drives tdi=data[i].
  - tms=0 on every cycle except the last, which drives tms=1 (→ Exit1).
  - jtag_tdo is sampled once per cycle into resp_data[i].
- POST:
  - TMS = 1,0 (Update → Run-Test/Idle), tdi=1.
- Edge totals:
  - DR scan: L+5 TCK cycles.
  - IR scan: L+6 TCK cycles.
- RESP:
  - resp_valid=1, resp_data held stable, tck=0, tms=0, req_ready=0.
  - The resp_valid & resp_ready handshake returns the block to IDLE.
- req_ready and resp_valid are never 1 in the same cycle.
- A new request is not accepted until the response is consumed.

## Timing
- TCK cycle = 2·CLK_DIV clocks: a low phase of CLK_DIV clocks, then a high phase of CLK_DIV clocks.
- tms/tdi change only on the clock edge that drives tck 1→0 (or starts the first low phase), so they are stable through the entire following rising edge.
- jtag_tdo is sampled on the clock edge that ends a high phase (tck 1→0):
  - The target updates TDO on the TCK falling edge, so TDO is stable at this point.
  - No synchronizer is used.
- Latency from request handshake:
  - The first low phase starts on the next clock.
  - resp_valid rises on the clock after the last high phase ends.
  - Total: (edges·2·CLK_DIV)+1 clocks.
  - Example: DR, L=32, CLK_DIV=2 → 37·4+1 = 149.
- INIT completes 6·2·CLK_DIV clocks after reset deasserts; req_ready rises on the following clock.
- Reset asserted at any point (mid-shift, in RESP):
  - All outputs take reset values on the next clock edge.
  - The partial scan is discarded with no response.
  - INIT is rerun after reset deasserts.
- resp_ready held low: resp_valid and resp_data stay stable indefinitely, with no TCK activity.

## Test plan
- Reset release (CLK_DIV=2):
  - Exactly 6 tck rising edges with tms 1,1,1,1,1,0.
  - req_ready rises 25 clocks after reset deasserts.
  - tck stays at 0 afterwards.
- DR scan, len=32, data 0x00010000, against a TAP model whose DTMCS captures 0x00005071:
  - 37 edges.
  - resp_data=0x00005071.
  - The model sees an Update with dmireset (bit 16) set.
  - resp_valid rises 149 clocks after the handshake.
- IR scan, len=5, data 0x10:
  - tms sequence 1,1,0,0,0,0,0,0,1,1,0 (11 edges).
  - tdi on the shift edges is 0,0,0,0,1.
  - The model IR becomes 0x10.
- DR scan, len=0:
  - 5 edges with tms 1,0,1,1,0.
  - resp_data=0.
  - The TAP model passes Capture→Exit1 with no shift.
- len=50 with MAX_LEN=41, and resp_ready held low 10 clocks after resp_valid:
  - 46 edges.
  - resp_valid and resp_data stable, req_ready=0, and no tck toggles during the stall.
- Reset asserted on shift edge 10 of a 41-bit DR scan:
  - tck=0, tms=1, tdi=1, resp_valid=0 on the next clock.
  - No response is produced.
  - After release, INIT runs again and the TAP model returns to Run-Test/Idle.

Source files
------------

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: bit-banged JTAG initiator running one IR or DR scan
// from Run-Test/Idle back to Run-Test/Idle, returning captured TDO bits.
module jtag_scan_master #(
  parameter int MAX_LEN = 41,
  parameter int CLK_DIV = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_ir,
  input  logic [$clog2(MAX_LEN+1)-1:0] req_len,
  input  logic [MAX_LEN-1:0]           req_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [MAX_LEN-1:0]           resp_data,
  output logic                         jtag_tck,
  output logic                         jtag_tms,
  output logic                         jtag_tdi,
  input  logic                         jtag_tdo
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int CW = $clog2(2*CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(2*CLK_DIV-1);
  localparam logic [CW-1:0] CNT_HI  = CW'(CLK_DIV);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RESP
  } state_t;

  state_t               state_q, state_d, nstate;
  logic [LW-1:0]        idx_q, idx_d, nidx;
  logic                 start_q, start_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 tck_q, tck_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;
  logic                 ir_q, ir_d;
  logic [LW-1:0]        len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [MAX_LEN-1:0]   resp_data_q, resp_data_d;
  logic [LW-1:0]        pre_last, len_last, len_clamp;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ir_d        = ir_q;
    len_d       = len_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    nstate      = state_q;
    nidx        = idx_q;
    pre_last    = ir_q ? LW'(3) : LW'(2);
    len_last    = len_q - LW'(1);
    len_clamp   = (req_len > LEN_MAX) ? LEN_MAX : req_len;
    cnt_inc     = cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_PRE;
          idx_d       = '0;
          start_d     = 1'b1;
          cnt_d       = CNT_MAX;
          ir_d        = req_ir;
          len_d       = len_clamp;
          data_d      = req_data;
          resp_data_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_inc;
          tck_d = (cnt_inc >= CNT_HI);
        end else begin
          // end of a high phase: close current TCK cycle, open the next
          cnt_d   = '0;
          tck_d   = 1'b0;
          start_d = 1'b0;
          if (!start_q) begin
            unique case (state_q)
              S_INIT: begin
                if (idx_q == LW'(5)) nstate = S_IDLE;
                else nidx = idx_q + LW'(1);
              end
              S_PRE: begin
                if (idx_q == pre_last) begin
                  nstate = (len_q == '0) ? S_POST : S_SHIFT;
                  nidx   = '0;
                end else begin
                  nidx = idx_q + LW'(1);
                end
              end
              S_SHIFT: begin
                resp_data_d[idx_q] = jtag_tdo;
                if (idx_q == len_last) begin
                  nstate = S_POST;
                  nidx   = '0;
                end else begin
                  nidx = idx_q + LW'(1);
                end
              end
              S_POST: begin
                if (idx_q != '0) nstate = S_RESP;
                else nidx = LW'(1);
              end
              default: ;
            endcase
          end
          state_d = nstate;
          idx_d   = nidx;
          unique case (nstate)
            S_INIT: begin
              tms_d = (nidx != LW'(5));
              tdi_d = 1'b1;
            end
            S_PRE: begin
              tdi_d = 1'b1;
              if (nidx == pre_last) tms_d = (len_q == '0);
              else tms_d = (nidx == '0) || (ir_q && nidx == LW'(1));
            end
            S_SHIFT: begin
              tms_d = (nidx == len_last);
              tdi_d = data_q[nidx];
            end
            S_POST: begin
              tms_d = (nidx == '0);
              tdi_d = 1'b1;
            end
            default: begin
              tms_d = 1'b0;
              tdi_d = 1'b1;
              cnt_d = CNT_MAX;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      start_q     <= 1'b1;
      cnt_q       <= CNT_MAX;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b1;
      ir_q        <= 1'b0;
      len_q       <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ir_q        <= ir_d;
      len_q       <= len_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign jtag_tck   = tck_q;
  assign jtag_tms   = tms_q;
  assign jtag_tdi   = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target plus randomized scans
// checked against expectations derived from register widths and captures.
module tb_jtag_scan_master;

  localparam int ML = 41;
  localparam int CD = 2;
  localparam int LW = $clog2(ML+1);
  localparam logic [31:0] DTMCS_CAP = 32'h0000_5071;
  localparam logic [31:0] IDCODE    = 32'h2000_0913;
  localparam logic [40:0] DMI_CAP   = 41'h0F0_F0F0_3C3C;

  localparam int T_TLR = 0,  T_RTI = 1,  T_SDS = 2,  T_CDR = 3;
  localparam int T_SDR = 4,  T_E1D = 5,  T_PDR = 6,  T_E2D = 7;
  localparam int T_UDR = 8,  T_SIS = 9,  T_CIR = 10, T_SIR = 11;
  localparam int T_E1I = 12, T_PIR = 13, T_E2I = 14, T_UIR = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ir = 1'b0;
  logic [LW-1:0] req_len = '0;
  logic [ML-1:0] req_data = '0;
  logic          resp_ready = 1'b0;
  logic          req_ready, resp_valid;
  logic [ML-1:0] resp_data;
  logic          jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

  jtag_scan_master #(.MAX_LEN(ML), .CLK_DIV(CD)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ir     (req_ir),
    .req_len    (req_len),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_tdo   (jtag_tdo)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dr_w(input logic [4:0] ir);
    if (ir == 5'h10) return 32;
    if (ir == 5'h11) return 41;
    if (ir == 5'h01) return 32;
    return 1;
  endfunction

  function automatic logic [63:0] dr_cap(input logic [4:0] ir);
    if (ir == 5'h10) return 64'(DTMCS_CAP);
    if (ir == 5'h11) return 64'(DMI_CAP);
    if (ir == 5'h01) return 64'(IDCODE);
    return 64'd0;
  endfunction

  function automatic int tap_next(input int s, input logic t);
    case (s)
      T_TLR:   return t ? T_TLR : T_RTI;
      T_RTI:   return t ? T_SDS : T_RTI;
      T_SDS:   return t ? T_SIS : T_CDR;
      T_CDR:   return t ? T_E1D : T_SDR;
      T_SDR:   return t ? T_E1D : T_SDR;
      T_E1D:   return t ? T_UDR : T_PDR;
      T_PDR:   return t ? T_E2D : T_PDR;
      T_E2D:   return t ? T_UDR : T_SDR;
      T_UDR:   return t ? T_SDS : T_RTI;
      T_SIS:   return t ? T_TLR : T_CIR;
      T_CIR:   return t ? T_E1I : T_SIR;
      T_SIR:   return t ? T_E1I : T_SIR;
      T_E1I:   return t ? T_UIR : T_PIR;
      T_PIR:   return t ? T_E2I : T_PIR;
      T_E2I:   return t ? T_UIR : T_SIR;
      default: return t ? T_SDS : T_RTI;
    endcase
  endfunction

  // target TAP, deliberately started mid Shift-DR
  int          tap_st = T_SDR;
  logic [4:0]  tap_ir = 5'h01;
  logic [63:0] tap_sr = '0;
  int          tap_w = 1;
  logic [31:0] dtmcs_upd = '0;
  int          edge_cnt = 0;
  int          shift_cnt = 0;
  int          capex_cnt = 0;
  logic        tms_log [0:8191];
  logic        tdi_log [0:8191];
  logic        tdo_m = 1'b0;

  assign jtag_tdo = tdo_m;

  initial forever begin
    @(posedge jtag_tck);
    if (edge_cnt < 8192) tms_log[edge_cnt] = jtag_tms;
    edge_cnt++;
    case (tap_st)
      T_TLR: tap_ir = 5'h01;
      T_CDR: begin
        tap_w  = dr_w(tap_ir);
        tap_sr = dr_cap(tap_ir);
      end
      T_CIR: begin
        tap_w  = 5;
        tap_sr = 64'h1;
      end
      T_SDR, T_SIR: begin
        if (shift_cnt < 8192) tdi_log[shift_cnt] = jtag_tdi;
        shift_cnt++;
        tap_sr = tap_sr >> 1;
        tap_sr[tap_w-1] = jtag_tdi;
      end
      T_UDR: if (tap_ir == 5'h10) dtmcs_upd = tap_sr[31:0];
      T_UIR: tap_ir = tap_sr[4:0];
      default: ;
    endcase
    if ((tap_st == T_CDR || tap_st == T_CIR) && jtag_tms) capex_cnt++;
    tap_st = tap_next(tap_st, jtag_tms);
  end

  initial forever begin
    @(negedge jtag_tck);
    tdo_m = (tap_st == T_SDR || tap_st == T_SIR) ? tap_sr[0] : 1'b0;
  end

  function automatic logic [127:0] pack_tms(input int e0, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n && i < 128; i++)
      if (e0 + i < 8192) v[i] = tms_log[e0+i];
    return v;
  endfunction

  function automatic logic [127:0] pack_tdi(input int s0, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n && i < 128; i++)
      if (s0 + i < 8192) v[i] = tdi_log[s0+i];
    return v;
  endfunction

  function automatic logic [127:0] lmask(input int n);
    if (n == 0) return '0;
    return (128'd1 << n) - 128'd1;
  endfunction

  logic [4:0]    exp_ir = 5'h01;
  logic [ML-1:0] r_resp;
  int            r_lat, r_edges, r_e0, r_s0, r_c0;

  task automatic init_check(input string tag);
    int e0, k;
    e0 = edge_cnt;
    k  = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (!req_ready && k < 200);
    chk({tag, "_rdy_lat"}, k, 25);
    chk({tag, "_edges"}, edge_cnt - e0, 6);
    chk({tag, "_tms"}, pack_tms(e0, 6), 6'h1F);
    chk({tag, "_tap_rti"}, tap_st, T_RTI);
    repeat (8) @(posedge clock);
    #1 chk({tag, "_tck_idle"}, {jtag_tck, 32'(edge_cnt - e0)},
           {1'b0, 32'd6});
    exp_ir = 5'h01;
  endtask

  task automatic do_scan(input logic ir, input int len,
                         input logic [ML-1:0] data, input int stall);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_ir    = ir;
    req_len   = LW'(len);
    req_data  = data;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("hs_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    r_e0 = edge_cnt;
    r_s0 = shift_cnt;
    r_c0 = capex_cnt;
    @(posedge clock);
    #1 req_valid = 1'b0;
    r_lat = 0;
    do begin
      @(posedge clock); #1;
      r_lat++;
    end while (!resp_valid && r_lat < 2000);
    if (!resp_valid) chk("resp_timeout", 0, 1);
    r_resp  = resp_data;
    r_edges = edge_cnt - r_e0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, r_resp);
      chk("stall_rdy", req_ready, 0);
      chk("stall_tck", {jtag_tck, 32'(edge_cnt - r_e0)},
          {1'b0, 32'(r_edges)});
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    chk("resp_done", {req_ready, resp_valid}, 2'b10);
  endtask

  task automatic scan_chk(input string tag, input logic ir, input int len,
                          input logic [ML-1:0] data, input int stall);
    int lc, w, ne;
    logic [127:0] cap, full;
    lc = (len > ML) ? ML : len;
    if (ir) begin
      w   = 5;
      cap = 128'h1;
    end else begin
      w   = dr_w(exp_ir);
      cap = 128'(dr_cap(exp_ir));
    end
    full = (128'(data) << w) | cap;
    ne   = lc + (ir ? 6 : 5);
    do_scan(ir, len, data, stall);
    chk({tag, "_resp"}, r_resp, full & lmask(lc));
    chk({tag, "_edges"}, r_edges, ne);
    chk({tag, "_lat"}, r_lat, ne * 2 * CD + 1);
    chk({tag, "_tdi"}, pack_tdi(r_s0, lc), 128'(data) & lmask(lc));
    if (ir) exp_ir = full[lc +: 5];
    chk({tag, "_ir"}, tap_ir, exp_ir);
  endtask

  initial begin
    logic          ir;
    int            len, stall, n;
    logic [ML-1:0] d;
    logic          seen;

    repeat (3) @(posedge clock);
    #1 chk("rst_pins", {jtag_tck, jtag_tms, jtag_tdi, req_ready, resp_valid},
           5'b01100);
    chk("rst_data", resp_data, 0);
    @(negedge clock);
    reset = 1'b1;
    init_check("init");

    scan_chk("ir_dtmcs", 1'b1, 5, 41'h10, 0);
    chk("ir_dtmcs_tms", pack_tms(r_e0, 11), 11'h303);

    scan_chk("dr_dtmcs", 1'b0, 32, 41'h0001_0000, 0);
    chk("dr_dtmcs_val", r_resp, 32'h0000_5071);
    chk("dr_dtmcs_149", r_lat, 149);
    chk("dr_dtmcs_upd", dtmcs_upd, 32'h0001_0000);
    chk("dr_dmireset", dtmcs_upd[16], 1);

    scan_chk("dr_zero", 1'b0, 0, ML'({$urandom(), $urandom()}), 0);
    chk("dr_zero_tms", pack_tms(r_e0, 5), 5'h0D);
    chk("dr_zero_noshift", shift_cnt - r_s0, 0);
    chk("dr_zero_capex", capex_cnt - r_c0, 1);

    scan_chk("dr_clamp", 1'b0, 50, ML'({$urandom(), $urandom()}), 10);
    chk("dr_clamp_46", r_edges, 46);

    for (int t = 0; t < 24; t++) begin
      ir  = ($urandom_range(0, 2) == 0);
      len = $urandom_range(0, 50);
      d   = ML'({$urandom(), $urandom()});
      if (ir && $urandom_range(0, 1) == 1) begin
        len = 5;
        case ($urandom_range(0, 2))
          0:       d = 41'h10;
          1:       d = 41'h11;
          default: d = 41'h01;
        endcase
      end
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      scan_chk("rnd", ir, len, d, stall);
    end

    // reset in the middle of a full-length DR shift
    @(negedge clock);
    req_valid = 1'b1;
    req_ir    = 1'b0;
    req_len   = LW'(ML);
    req_data  = ML'({$urandom(), $urandom()});
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    r_s0 = shift_cnt;
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    while (shift_cnt - r_s0 < 10 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("mid_reach", shift_cnt - r_s0, 10);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 chk("mid_rst_pins",
           {jtag_tck, jtag_tms, jtag_tdi, resp_valid, req_ready}, 5'b01100);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      seen = seen | resp_valid | jtag_tck;
    end
    chk("mid_quiet", seen, 0);
    @(negedge clock);
    reset = 1'b1;
    init_check("reinit");
    chk("reinit_noresp", resp_valid, 0);
    chk("reinit_ir", tap_ir, 5'h01);

    scan_chk("post_rst", 1'b0, 32, ML'({$urandom(), $urandom()}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
